apb_regfile_param: RTL and testbench
====================================

// Module: apb_regfile_param
// PURPOSE
//  Parametrised APB4 slave register file: NUM_REGS word registers at word-aligned offsets 0x00..4*(NUM_REGS-1).
//  Adds over the fixed 16x32 slave: programmable wait states (PREADY), byte strobes (PSTRB),
//  PSLVERR on bad access, per-register read-only mask with hardware-driven RO values.
//  Sits on the peripheral APB segment; register contents exported flat to the device core.
// PARAMETERS
//  ADDR_W       32     PADDR width
//  DATA_W       32     data width; multiple of 8; STRB_W = DATA_W/8
//  NUM_REGS     16     register count, 1..256; IDX_W = max(1,$clog2(NUM_REGS))
//  WAIT_STATES  0      extra ACCESS cycles before PREADY, 0..15
//  RO_MASK      '0     NUM_REGS bits; bit i=1 -> register i read-only, value from hw_in
//  RESET_VAL    '0     DATA_W reset value of every writable register
// PORTS
//  PCLK     in   1                  clock, all logic on rising edge
//  PRESET   in   1                  synchronous reset, active-high
//  PSEL     in   1                  slave select
//  PENABLE  in   1                  access phase
//  PWRITE   in   1                  1=write 0=read
//  PADDR    in   ADDR_W             byte address
//  PWDATA   in   DATA_W             write data
//  PSTRB    in   STRB_W             write byte lanes
//  PRDATA   out  DATA_W             read data, valid when PREADY=1
//  PREADY   out  1                  transfer completes this cycle
//  PSLVERR  out  1                  error, valid only when PREADY=1
//  reg_out  out  NUM_REGS*DATA_W    all register values, reg i at [i*DATA_W +: DATA_W]
//  hw_in    in   NUM_REGS*DATA_W    values for RO registers; unused bits for RW regs ignored
// BEHAVIOUR
//  - Reset (PRESET=1 at edge): FSM=IDLE, RW regs=RESET_VAL, cnt=0; PREADY=0, PSLVERR=0, PRDATA=0.
//  - FSM IDLE: PSEL&!PENABLE -> latch PADDR/PWRITE/PWDATA/PSTRB, cnt<=WAIT_STATES, go ACCESS.
//    PENABLE without prior setup is ignored (stay IDLE).
//  - FSM ACCESS: PREADY = (cnt==0) combinationally from state; each cycle with PSEL&PENABLE&cnt!=0 -> cnt--.
//    Completion edge = PSEL&PENABLE&PREADY: commit write (if legal), go IDLE.
//    PSEL=0 in ACCESS -> abort, no write, go IDLE.
//  - Latency: WAIT_STATES=0 -> PREADY in first ACCESS cycle (2-cycle transfer); N -> 2+N cycles.
//  - Back-to-back: setup cycle immediately after completion is accepted (IDLE sees it same cycle).
//  - Decode: idx=latched PADDR[IDX_W+1:2].
//    Error if PADDR[1:0]!=0, PADDR>=4*NUM_REGS, or write to RO register.
//  - Error: PSLVERR=1 and PRDATA=0 only in completion cycle; no register modified.
//  - Write: lane b of reg idx <= PWDATA lane b where PSTRB[b]=1; others hold. PSTRB=0 -> legal no-op.
//  - Read: PRDATA = RO ? hw_in[idx] : reg[idx] during completion cycle; 0 in every other cycle.
//  - reg_out: RW regs stored value (updates edge after commit); RO regs = hw_in passthrough.
//  - PREADY, PSLVERR are 0 outside ACCESS.
//  - PRESET mid-transfer: abort immediately, no write, all outputs to reset values next cycle.
// TESTING
//  1 reset, WAIT_STATES=0: write 0x1000_0000 @0x04 PSTRB=F -> PREADY in 1st ACCESS cycle, PSLVERR=0; read @0x04 -> 0x1000_0000
//  2 reg@0x08=0x1122_3344, write 0xAABB_CCDD PSTRB=4'b0101 -> read 0x11BB_33DD
//  3 WAIT_STATES=3: write @0x0C -> PREADY=0 for 3 ACCESS cycles, 1 on 4th; reg_out unchanged until after 4th edge
//  4 NUM_REGS=16: read @0x40 and write @0x06 -> PSLVERR=1, PRDATA=0, all regs unchanged
//  5 RO_MASK[0]=1, hw_in[0]=0xDEAD_BEEF: write @0x00 -> PSLVERR=1; read @0x00 -> 0xDEAD_BEEF
//  6 WAIT_STATES=2, PRESET=1 during 2nd ACCESS cycle -> next cycle PREADY=0, regs=RESET_VAL; back-to-back transfers after release succeed

Source files
------------

// File: rtl/apb_regfile_param.sv
// apb_regfile_param: APB4 slave register file with wait states, byte strobes,
// error response and hardware-driven read-only registers exported flat to the core.

module apb_regfile_word #(
  parameter int                 DATA_W    = 32,
  parameter int                 STRB_W    = DATA_W / 8,
  parameter bit                 RO        = 1'b0,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [STRB_W-1:0] strb,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] hw_val,
  output logic [DATA_W-1:0] q
);
  if (RO) begin : g_ro
    // Read-only words carry no storage; the core owns the value.
    logic unused_ro;
    assign unused_ro = ^{clk, rst, we, strb, wdata};
    assign q = hw_val;
  end else begin : g_rw
    logic [DATA_W-1:0] q_r;
    logic              unused_hw;
    assign unused_hw = ^hw_val;

    always_ff @(posedge clk) begin
      if (rst) begin
        q_r <= RESET_VAL;
      end else if (we) begin
        for (int b = 0; b < STRB_W; b++)
          if (strb[b]) q_r[b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    assign q = q_r;
  end
endmodule

module apb_regfile_param #(
  parameter int                  ADDR_W      = 32,
  parameter int                  DATA_W      = 32,
  parameter int                  NUM_REGS    = 16,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  parameter logic [DATA_W-1:0]   RESET_VAL   = '0
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [ADDR_W-1:0]            PADDR,
  input  logic [DATA_W-1:0]            PWDATA,
  input  logic [DATA_W/8-1:0]          PSTRB,
  output logic [DATA_W-1:0]            PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_in
);
  localparam int STRB_W    = DATA_W / 8;
  localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int NUM_SLOTS = 1 << IDX_W;
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * NUM_REGS);

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } apb_req_t;

  state_t   state;
  logic [3:0] cnt;
  apb_req_t req;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
      cnt   <= '0;
      req   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // An ACCESS phase without a preceding SETUP is not a transfer.
          if (PSEL && !PENABLE) begin
            req   <= '{addr: PADDR, wr: PWRITE, wdata: PWDATA, strb: PSTRB};
            cnt   <= 4'(WAIT_STATES);
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!PSEL)
            state <= IDLE;
          else if (PENABLE) begin
            if (cnt != 4'd0) cnt <= cnt - 4'd1;
            else             state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [IDX_W-1:0]                    idx;
  logic                                in_range;
  logic                                err;
  logic                                ready;
  logic                                we_word;
  logic [NUM_SLOTS-1:0]                ro_slot;
  logic [NUM_SLOTS-1:0][DATA_W-1:0]    slot_q;
  logic [NUM_REGS-1:0][DATA_W-1:0]     hw_w;
  logic [NUM_REGS-1:0][DATA_W-1:0]     reg_q;

  assign idx      = req.addr[IDX_W+1:2];
  assign in_range = {1'b0, req.addr} < ADDR_LIMIT;
  assign err      = (req.addr[1:0] != 2'b00) || !in_range || (req.wr && ro_slot[idx]);
  assign ready    = (state == ACCESS) && (cnt == 4'd0);
  assign we_word  = ready && PSEL && PENABLE && req.wr && !err;

  assign PREADY  = ready;
  assign PSLVERR = ready && err;
  assign PRDATA  = (ready && !req.wr && !err) ? slot_q[idx] : '0;

  assign hw_w    = hw_in;
  assign reg_out = reg_q;

  // Slots past NUM_REGS pad the decode to a power of two; they are always errors.
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    if (i < NUM_REGS) begin : g_reg
      apb_regfile_word #(
        .DATA_W    (DATA_W),
        .STRB_W    (STRB_W),
        .RO        (RO_MASK[i]),
        .RESET_VAL (RESET_VAL)
      ) u_word (
        .clk    (PCLK),
        .rst    (PRESET),
        .we     (we_word && (idx == IDX_W'(i))),
        .strb   (req.strb),
        .wdata  (req.wdata),
        .hw_val (hw_w[i]),
        .q      (reg_q[i])
      );
      assign slot_q[i]  = reg_q[i];
      assign ro_slot[i] = RO_MASK[i];
    end else begin : g_pad
      assign slot_q[i]  = '0;
      assign ro_slot[i] = 1'b0;
    end
  end
endmodule

// File: tb/tb_apb_regfile_param.sv
// Bench for apb_regfile_param: three instances (0/3/2 wait states) driven with
// directed and random APB traffic, scored against a word-array model.

module tb_apb_regfile_param;
  logic clk;
  int unsigned checks   = 0;
  int unsigned failures = 0;

  typedef struct {
    bit          rd;
    bit          err;
    logic [31:0] data;
  } exp_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int          WS = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
    localparam logic [15:0] RO = (g == 1) ? 16'h0201 : 16'h0001;
    localparam logic [31:0] RV = (g == 2) ? 32'h0000_5A5A : 32'h0;

    logic          preset, psel, penable, pwrite;
    logic [31:0]   paddr, pwdata, prdata;
    logic [3:0]    pstrb;
    logic          pready, pslverr;
    logic [511:0]  reg_out, hw_in;
    logic [31:0]   mem [16];
    exp_t          q [$];
    bit            done = 1'b0;
    bit            mon_en = 1'b0;

    apb_regfile_param #(
      .ADDR_W(32), .DATA_W(32), .NUM_REGS(16), .WAIT_STATES(WS),
      .RO_MASK(RO), .RESET_VAL(RV)
    ) u_dut (
      .PCLK(clk), .PRESET(preset), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata),
      .PREADY(pready), .PSLVERR(pslverr), .reg_out(reg_out), .hw_in(hw_in)
    );

    // One full transfer; expectation queued at SETUP, model updated after completion edge.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit b2b);
      exp_t e;
      int   idx, waits;
      bit   got;
      idx   = int'(a[5:2]);
      e.rd  = !wr;
      e.err = (a[1:0] != 2'b00) || (a >= 32'd64) || (wr && RO[idx]);
      e.data = (e.err || wr) ? 32'h0 : (RO[idx] ? hw_in[idx*32 +: 32] : mem[idx]);
      q.push_back(e);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
      @(posedge clk); #1;
      penable = 1'b1;
      waits = 0; got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        if (pready) got = 1'b1; else waits++;
        @(posedge clk); #1;
      end
      if (!got) begin
        checks++; failures++;
        $display("FAIL g%0d timeout: no PREADY within 40 cycles for addr 0x%08h", g, a);
        q.delete();
      end else begin
        chk($sformatf("g%0d latency @%08h", g, a), 32'(waits), 32'(WS));
        if (!e.err && wr)
          for (int b = 0; b < 4; b++)
            if (s[b]) mem[idx][b*8 +: 8] = d[b*8 +: 8];
      end
      psel = 1'b0; penable = 1'b0;
      if (!b2b) begin @(posedge clk); #1; end
    endtask

    task automatic reset_mid();
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = $urandom(); pstrb = 4'hF;
      if (WS == 0) begin
        preset = 1'b1;
        @(posedge clk); #1;
        preset = 1'b0; penable = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = RV;
        @(posedge clk); #1;
      end else begin
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        preset = 1'b1;
        @(posedge clk); #1;
        preset = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = RV;
      end
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
    endtask

    initial begin : drv
      logic [31:0] a;
      int r;
      preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;
      for (int i = 0; i < 16; i++) begin
        mem[i] = RV;
        hw_in[i*32 +: 32] = $urandom();
      end
      hw_in[31:0] = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      #1 preset = 1'b0; mon_en = 1'b1;
      @(posedge clk); #1;

      xfer(1'b1, 32'h04, 32'h1000_0000, 4'hF, 1'b1);
      xfer(1'b0, 32'h04, 32'h0,         4'hF, 1'b0);
      xfer(1'b1, 32'h08, 32'h1122_3344, 4'hF, 1'b0);
      xfer(1'b1, 32'h08, 32'hAABB_CCDD, 4'b0101, 1'b1);
      xfer(1'b0, 32'h08, 32'h0,         4'hF, 1'b0);
      xfer(1'b1, 32'h0C, 32'h1234_5678, 4'hF, 1'b0);
      xfer(1'b0, 32'h40, 32'h0,         4'hF, 1'b0);
      xfer(1'b1, 32'h06, 32'hFFFF_FFFF, 4'hF, 1'b0);
      xfer(1'b1, 32'h00, 32'hCAFE_F00D, 4'hF, 1'b0);
      xfer(1'b0, 32'h00, 32'h0,         4'hF, 1'b0);
      xfer(1'b1, 32'h10, 32'h0000_0055, 4'h0, 1'b1);
      xfer(1'b0, 32'h10, 32'h0,         4'hF, 1'b0);

      reset_mid();
      xfer(1'b1, 32'h14, 32'h0BAD_CAFE, 4'hF, 1'b1);
      xfer(1'b0, 32'h14, 32'h0,         4'hF, 1'b1);
      xfer(1'b0, 32'h0C, 32'h0,         4'hF, 1'b0);

      for (int n = 0; n < 60; n++) begin
        if ($urandom_range(0, 7) == 0)
          hw_in[$urandom_range(1, 15)*32 +: 32] = $urandom();
        r = int'($urandom_range(0, 9));
        if (r == 0)
          a = ($urandom_range(0, 15) * 4) | $urandom_range(1, 3);
        else if (r == 1)
          a = $urandom_range(0, 1) ? (32'h40 + $urandom_range(0, 15) * 4)
                                   : (($urandom() & 32'hFFFF_FFFC) | 32'h100);
        else
          a = $urandom_range(0, 15) * 4;
        xfer(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)));
      end
      repeat (2) @(posedge clk);
      chk($sformatf("g%0d scoreboard drained", g), 32'(q.size()), 32'h0);
      done = 1'b1;
    end

    always @(negedge clk) begin : mon
      exp_t        e;
      logic [511:0] ev;
      if (mon_en && !done) begin
        for (int i = 0; i < 16; i++)
          ev[i*32 +: 32] = RO[i] ? hw_in[i*32 +: 32] : mem[i];
        checks++;
        if (reg_out !== ev) begin
          failures++;
          for (int i = 0; i < 16; i++)
            if (reg_out[i*32 +: 32] !== ev[i*32 +: 32]) begin
              $display("FAIL g%0d reg_out[%0d]: got 0x%08h expected 0x%08h",
                       g, i, reg_out[i*32 +: 32], ev[i*32 +: 32]);
              break;
            end
        end
        if (pready) begin
          if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL g%0d unexpected PREADY: got 1 expected 0", g);
          end else begin
            e = q.pop_front();
            chk($sformatf("g%0d PSLVERR", g), {31'h0, pslverr}, {31'h0, e.err});
            if (e.rd || e.err)
              chk($sformatf("g%0d PRDATA", g), prdata, e.data);
          end
        end else begin
          chk($sformatf("g%0d idle PRDATA/PSLVERR", g), {pslverr, prdata[30:0]} | {31'h0, |prdata},
              32'h0);
        end
      end
    end
  end

  initial begin : top
    bit all_done;
    all_done = 1'b0;
    for (int t = 0; t < 30000 && !all_done; t++) begin
      @(posedge clk);
      all_done = gi[0].done && gi[1].done && gi[2].done;
    end
    if (!all_done) begin
      checks++; failures++;
      $display("FAIL run timeout: got unfinished expected all instances done");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
